// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
// Used by mem_arbiter and arb_pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Read data returned to a requester whose access timed out.
    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between instruction and data requesters.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is data-over-instruction priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_served,
    output logic grant_valid,
    output logic grant
);

    // Winner select; with no request the grant simply repeats the last owner.
    always_comb begin
        grant_valid = i_req | d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            grant = ~last_served;
        end else if (d_req) begin
            grant = OWN_D;
        end else if (i_req) begin
            grant = OWN_I;
        end else begin
            grant = last_served;
        end
`else
        if (d_req) begin
            grant = OWN_D;
        end else if (i_req) begin
            grant = OWN_I;
        end else begin
            grant = last_served;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data-cache accesses onto one memory handshake,
// with per-port read data registers and an acknowledge timeout (MEM_ARB_ROUND_ROBIN_EN selects arbitration).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_read_ready,
    input  logic          mem_write_done,
    output logic          owner,
    output logic          bus_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t        state_r;
    logic          we_r;
    logic          last_served_r;
    logic [CW-1:0] tcnt_r;
    logic          grant_valid_s;
    logic          grant_s;
    logic          ack_s;
    logic          timeout_s;

    arb_pick u_arb_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_served (last_served_r),
        .grant_valid (grant_valid_s),
        .grant       (grant_s)
    );

    // Only the acknowledge matching the latched direction completes an access.
    always_comb begin
        if (we_r) begin
            ack_s = mem_write_done;
        end else begin
            ack_s = mem_read_ready;
        end
        if ((TIMEOUT != 0) && ((int'(tcnt_r) + 1) >= TIMEOUT)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Arbiter FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            we_r          <= 1'b0;
            last_served_r <= OWN_D;
            tcnt_r        <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            i_rdata       <= '0;
            d_rdata       <= '0;
            i_done        <= 1'b0;
            d_done        <= 1'b0;
            bus_err       <= 1'b0;
            owner         <= OWN_I;
        end else begin
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            bus_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        owner         <= grant_s;
                        last_served_r <= grant_s;
                        tcnt_r        <= '0;
                        state_r       <= ACCESS;
                        if (grant_s == OWN_D) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            we_r      <= d_we;
                            mem_write <= d_we;
                            mem_read  <= ~d_we;
                        end else begin
                            mem_addr  <= i_addr;
                            we_r      <= 1'b0;
                            mem_write <= 1'b0;
                            mem_read  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (ack_s) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state_r   <= DONE;
                        if (owner == OWN_D) begin
                            d_done <= 1'b1;
                            if (!we_r) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            i_done  <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else if (timeout_s) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        bus_err   <= 1'b1;
                        state_r   <= DONE;
                        if (owner == OWN_D) begin
                            d_done  <= 1'b1;
                            d_rdata <= DW'(ERR_RDATA);
                        end else begin
                            i_done  <= 1'b1;
                            i_rdata <= DW'(ERR_RDATA);
                        end
                    end else begin
                        tcnt_r <= tcnt_r + CW'(1);
                    end
                end
                DONE: begin
                    tcnt_r  <= '0;
                    state_r <= IDLE;
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory read/write handshake between two requesters: the instruction-fetch port (read-only) and the data-cache controller port (read/write).
- Sits between the CPU top level and external memory.
- Serialises accesses and latches read data per requester.
- Raises a bus error if memory fails to acknowledge within a bounded number of cycles.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, maximum ACCESS cycles to wait for a memory acknowledge; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- i_req  in  1  instruction read request; held until i_done.
- i_addr  in  AW  instruction address.
- i_rdata  out  DW  registered read data for the instruction port.
- i_done  out  1  one-cycle completion pulse, instruction port.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  registered read data for the data port.
- d_done  out  1  one-cycle completion pulse, data port.
- mem_addr  out  AW  memory address (registered).
- mem_wdata  out  DW  memory write data (registered).
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_rdata  in  DW  memory read data.
- mem_read_ready  in  1  read data valid acknowledge.
- mem_write_done  in  1  write complete acknowledge.
- owner  out  1  current or last grant: 0 = instruction, 1 = data.
- bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - mem_read, mem_write, i_done, d_done, bus_err = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - owner = 0; timeout count = 0; round-robin last-served = data.
  - Reset in the middle of a transaction abandons it with no done pulse.
- FSM IDLE:
  - If any req is sampled high, pick a winner.
  - Latch addr, wdata, we (forced 0 for the instruction port) and owner.
  - Next state is ACCESS.
  - mem_read or mem_write rises on the edge that enters ACCESS.
- FSM ACCESS:
  - Strobe and mem_addr stay stable.
  - Read completes on mem_read_ready=1; write completes on mem_write_done=1.
  - On completion, latch mem_rdata into the winner's rdata register (reads only), drop the strobe and go to DONE.
  - Acknowledges of the wrong type are ignored.
  - The timeout counter increments on each ACCESS cycle without an acknowledge.
  - If the count reaches TIMEOUT (and TIMEOUT≠0): drop the strobe, pulse bus_err, load the winner's rdata with ERR_RDATA (32'hDEAD_BEEF), go to DONE.
  - Acknowledge and timeout in the same cycle: the acknowledge wins, no bus_err.
- FSM DONE:
  - Pulse the winner's done for exactly one cycle.
  - Clear the timeout counter.
  - Next state is IDLE.
- Acknowledges arriving in IDLE or DONE are ignored.
- Requester rule:
  - Deassert req on the edge where done is sampled high.
  - A req still high in the following IDLE cycle is treated as a new request.
  - Dropping req mid-transaction does not abort it; done still pulses.
- Latency:
  - Request sampled at edge k gives strobe high at k+1.
  - Acknowledge sampled at edge m gives done high during cycle m+1.
  - Minimum request-to-done is 3 cycles.
- rdata registers hold their value until the next read for that port completes; writes do not change d_rdata.
- Arbitration without the macro: fixed priority, data over instruction.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - On simultaneous requests, grant the port not served last.
  - The last-served register updates on entry to ACCESS.
  - The last-served register resets to data, so the first tie goes to instruction.
  - A single requester is always granted.
- Undefined: fixed priority, data over instruction; the instruction port can starve under continuous data traffic.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, DONE};
  - owner constants OWN_I=1'b0 and OWN_D=1'b1;
  - ERR_RDATA.
- Sub-module arb_pick: combinational winner select from i_req, d_req and last_served; it contains the macro-dependent logic.
- The timeout counter width is $clog2(TIMEOUT+1).

Test Plan:
- Single instruction read: i_req=1, i_addr=0x100; memory asserts mem_read_ready 2 cycles after mem_read with mem_rdata=0xCAFE0001 -> mem_addr=0x100, i_rdata=0xCAFE0001, i_done pulses once, owner=0.
- Data write: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0x55AA55AA, mem_write_done after 1 cycle -> mem_write high exactly 1 cycle, mem_wdata=0x55AA55AA, d_done pulse, d_rdata unchanged.
- Simultaneous requests, repeated 4 times:
  - Without the macro: the data port is served first and the instruction port only after it.
  - With the macro: grants alternate I, D, I, D.
- Timeout with TIMEOUT=4, no acknowledge -> bus_err pulses after 4 ACCESS cycles, d_rdata=0xDEADBEEF, d_done pulses, FSM returns to IDLE.
- reset driven low during ACCESS -> outputs zero immediately, no done pulse; after release, a new request completes normally.
- Wrong-type acknowledge: mem_write_done during a read -> ignored, mem_read stays high until mem_read_ready arrives.
